pippo_wbarb: RTL and testbench

Write-back port arbiter for the pippo core. It shares the single GPR write port among the ALU, LSU load data, SPR reads and LSU effective-address update. It drives the `rfwb_op` select of pippo_wbmux together with the GPR write enable and address. It also sequences the second write of load-with-update instructions and back-pressures upstream stages when a requester loses arbitration.

---
 rtl/pippo_wbarb_pkg.sv | 16 +
 rtl/pippo_wbarb_if.sv | 43 ++++
 rtl/pippo_wbarb.sv | 115 +++++++++++
 tb/tb_pippo_wbarb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pippo_wbarb_pkg.sv
// pippo_wbarb_pkg
//   Shared definitions for the pippo write-back arbiter.
//   RFWBOP_* select encodings are shared with pippo_wbmux and the ID stage
//   and must not be renumbered.
package pippo_wbarb_pkg;

    localparam int unsigned RFWBOP_WIDTH = 2;

    typedef enum logic [RFWBOP_WIDTH-1:0] {
        RFWBOP_ALU = 2'b00,
        RFWBOP_LSU = 2'b01,
        RFWBOP_SPR = 2'b10,
        RFWBOP_EA  = 2'b11
    } rfwbop_e;

endpackage

// File: rtl/pippo_wbarb_if.sv
// pippo_wbarb_if
//   Request/grant bundle between the write-back requesters (ALU, LSU, SPR)
//   and the GPR write-port arbiter, plus the arbiter's write-port outputs.
//   master : requester side (drives *_req/*_addr, observes grants/port)
//   slave  : arbiter side   (observes requests, drives grants/port)
interface pippo_wbarb_if #(
    parameter int unsigned AW = 5
) ();
    import pippo_wbarb_pkg::*;

    logic                    alu_req;
    logic [AW-1:0]           alu_addr;
    logic                    lsu_req;
    logic [AW-1:0]           lsu_addr;
    logic                    lsu_upd;
    logic [AW-1:0]           lsu_upd_addr;
    logic                    spr_req;
    logic [AW-1:0]           spr_addr;

    logic                    alu_gnt;
    logic                    lsu_gnt;
    logic                    spr_gnt;
    logic [RFWBOP_WIDTH-1:0] rfwb_op;
    logic                    rf_we;
    logic [AW-1:0]           rf_addrw;
    logic                    wbarb_stall;
    logic                    upd_pend;

    modport master (
        output alu_req, alu_addr, lsu_req, lsu_addr, lsu_upd, lsu_upd_addr,
               spr_req, spr_addr,
        input  alu_gnt, lsu_gnt, spr_gnt, rfwb_op, rf_we, rf_addrw,
               wbarb_stall, upd_pend
    );

    modport slave (
        input  alu_req, alu_addr, lsu_req, lsu_addr, lsu_upd, lsu_upd_addr,
               spr_req, spr_addr,
        output alu_gnt, lsu_gnt, spr_gnt, rfwb_op, rf_we, rf_addrw,
               wbarb_stall, upd_pend
    );

endinterface

// File: rtl/pippo_wbarb.sv
// pippo_wbarb
//   Shares the single GPR write port among ALU, LSU load data, SPR reads and
//   the LSU effective-address update of load-with-update instructions.
//   Priority lsu > spr > alu, one grant per cycle; a granted load-with-update
//   is followed by one EA write cycle (state UPD) before arbitration resumes.
// Ports:
//   clk        core clock, rising edge
//   rst        asynchronous active-low reset
//   wb_freeze  pipeline freeze: no grants, no write, state held, no stall
//   wb         pippo_wbarb_if.slave: requests in; grants, rfwb_op, rf_we,
//              rf_addrw, wbarb_stall, upd_pend out (all combinational)
module pippo_wbarb
    import pippo_wbarb_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_freeze,
    pippo_wbarb_if.slave  wb
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_UPD  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] upd_addr_q, upd_addr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            upd_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            upd_addr_q <= upd_addr_d;
        end
    end

    logic          alu_gnt, lsu_gnt, spr_gnt;
    logic          wr_sel;
    logic [1:0]    op_sel;
    logic [AW-1:0] addr_sel;
    logic          any_req;

    always_comb begin
        state_d    = state_q;
        upd_addr_d = upd_addr_q;
        alu_gnt    = 1'b0;
        lsu_gnt    = 1'b0;
        spr_gnt    = 1'b0;
        wr_sel     = 1'b0;
        op_sel     = RFWBOP_ALU;
        addr_sel   = '0;
        any_req    = wb.alu_req | wb.lsu_req | wb.spr_req;

        if (!wb_freeze) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (wb.lsu_req) begin
                        lsu_gnt  = 1'b1;
                        wr_sel   = 1'b1;
                        op_sel   = RFWBOP_LSU;
                        addr_sel = wb.lsu_addr;
                        // EA write is skipped when it would target r0 or
                        // collide with the load destination (load data wins).
                        if (wb.lsu_upd && (wb.lsu_upd_addr != wb.lsu_addr) &&
                            (wb.lsu_upd_addr != '0)) begin
                            state_d    = ST_UPD;
                            upd_addr_d = wb.lsu_upd_addr;
                        end
                    end else if (wb.spr_req) begin
                        spr_gnt  = 1'b1;
                        wr_sel   = 1'b1;
                        op_sel   = RFWBOP_SPR;
                        addr_sel = wb.spr_addr;
                    end else if (wb.alu_req) begin
                        alu_gnt  = 1'b1;
                        wr_sel   = 1'b1;
                        op_sel   = RFWBOP_ALU;
                        addr_sel = wb.alu_addr;
                    end
                end
                ST_UPD: begin
                    wr_sel   = 1'b1;
                    op_sel   = RFWBOP_EA;
                    addr_sel = upd_addr_q;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        wb.alu_gnt     = alu_gnt;
        wb.lsu_gnt     = lsu_gnt;
        wb.spr_gnt     = spr_gnt;
        wb.rfwb_op     = op_sel;
        wb.rf_addrw    = addr_sel;
        // r0 is hard-wired zero: grant still given, write suppressed.
        wb.rf_we       = wr_sel && (addr_sel != '0);
        wb.wbarb_stall = !wb_freeze &&
                         ((wb.alu_req && !alu_gnt) ||
                          (wb.lsu_req && !lsu_gnt) ||
                          (wb.spr_req && !spr_gnt));
        wb.upd_pend    = (state_q == ST_UPD);
        if (wb_freeze) begin
            any_req = 1'b0;
        end
    end

    logic unused_any_req;
    assign unused_any_req = any_req;

endmodule

// File: tb/tb_pippo_wbarb.sv
module tb_pippo_wbarb;
    import pippo_wbarb_pkg::*;

    localparam int unsigned AW = 5;

    logic clk = 1'b0;
    logic rst;
    logic wb_freeze;

    always #5 clk = ~clk;

    pippo_wbarb_if #(.AW(AW)) bus ();

    pippo_wbarb #(.AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_freeze (wb_freeze),
        .wb        (bus.slave)
    );

    typedef struct {
        string         name;
        logic          alu_gnt, lsu_gnt, spr_gnt;
        logic [1:0]    op;
        logic          we;
        logic [AW-1:0] addr;
        logic          stall;
        logic          upd;
        logic          chk_port;   // op/addr only checked when fixed by design
    } exp_t;

    exp_t exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [2:0] gnt_als,
                                input logic [1:0] op, input logic we,
                                input logic [AW-1:0] addr, input logic stall,
                                input logic upd);
        exp_t e;
        e.name = name;
        e.alu_gnt = gnt_als[2];
        e.lsu_gnt = gnt_als[1];
        e.spr_gnt = gnt_als[0];
        e.op = op; e.we = we; e.addr = addr;
        e.stall = stall; e.upd = upd; e.chk_port = 1'b1;
        return e;
    endfunction

    task automatic compare_front();
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".alu_gnt"}, 32'(bus.alu_gnt), 32'(e.alu_gnt));
        chk({e.name, ".lsu_gnt"}, 32'(bus.lsu_gnt), 32'(e.lsu_gnt));
        chk({e.name, ".spr_gnt"}, 32'(bus.spr_gnt), 32'(e.spr_gnt));
        chk({e.name, ".rf_we"},   32'(bus.rf_we),   32'(e.we));
        chk({e.name, ".stall"},   32'(bus.wbarb_stall), 32'(e.stall));
        chk({e.name, ".upd_pend"}, 32'(bus.upd_pend), 32'(e.upd));
        if (e.chk_port) begin
            chk({e.name, ".rfwb_op"},  32'(bus.rfwb_op),  32'(e.op));
            chk({e.name, ".rf_addrw"}, 32'(bus.rf_addrw), 32'(e.addr));
        end
    endtask

    // Inputs are set just after a rising edge; expectation is queued, outputs
    // sampled mid-cycle, then the cycle is closed with the next rising edge.
    task automatic cycle(input exp_t e);
        exp_q.push_back(e);
        #3;
        compare_front();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        bus.alu_req = 1'b0; bus.alu_addr = '0;
        bus.lsu_req = 1'b0; bus.lsu_addr = '0;
        bus.lsu_upd = 1'b0; bus.lsu_upd_addr = '0;
        bus.spr_req = 1'b0; bus.spr_addr = '0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic upd, input logic [AW-1:0] ua);
        bus.lsu_req = 1'b1; bus.lsu_addr = a;
        bus.lsu_upd = upd;  bus.lsu_upd_addr = ua;
    endtask

    task automatic drop_lsu();
        bus.lsu_req = 1'b0; bus.lsu_upd = 1'b0;
    endtask

    exp_t ef;

    initial begin
        rst = 1'b0;
        wb_freeze = 1'b0;
        clr_req();

        // Reset state
        #2;
        exp_q.push_back(mk("reset", 3'b000, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0));
        compare_front();
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(mk("idle", 3'b000, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0));

        // Single ALU write
        bus.alu_req = 1'b1; bus.alu_addr = 5'd3;
        cycle(mk("alu3", 3'b100, 2'b00, 1'b1, 5'd3, 1'b0, 1'b0));
        clr_req();

        // Three-way contention
        bus.alu_req = 1'b1; bus.alu_addr = 5'd5;
        bus.spr_req = 1'b1; bus.spr_addr = 5'd6;
        load(5'd7, 1'b0, 5'd0);
        cycle(mk("pri_c0", 3'b010, 2'b01, 1'b1, 5'd7, 1'b1, 1'b0));
        drop_lsu();
        cycle(mk("pri_c1", 3'b001, 2'b10, 1'b1, 5'd6, 1'b1, 1'b0));
        bus.spr_req = 1'b0;
        cycle(mk("pri_c2", 3'b100, 2'b00, 1'b1, 5'd5, 1'b0, 1'b0));
        clr_req();

        // Load-with-update, ALU waiting
        bus.alu_req = 1'b1; bus.alu_addr = 5'd2;
        load(5'd4, 1'b1, 5'd9);
        cycle(mk("upd_c0", 3'b010, 2'b01, 1'b1, 5'd4, 1'b1, 1'b0));
        drop_lsu();
        cycle(mk("upd_c1", 3'b000, 2'b11, 1'b1, 5'd9, 1'b1, 1'b1));
        cycle(mk("upd_c2", 3'b100, 2'b00, 1'b1, 5'd2, 1'b0, 1'b0));
        clr_req();

        // Update address equals load address: single write
        load(5'd8, 1'b1, 5'd8);
        cycle(mk("same_c0", 3'b010, 2'b01, 1'b1, 5'd8, 1'b0, 1'b0));
        drop_lsu();
        cycle(mk("same_c1", 3'b000, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0));

        // Update address zero: no EA cycle
        load(5'd10, 1'b1, 5'd0);
        cycle(mk("zero_c0", 3'b010, 2'b01, 1'b1, 5'd10, 1'b0, 1'b0));
        drop_lsu();
        cycle(mk("zero_c1", 3'b000, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0));

        // Write to r0: granted, no write enable
        bus.alu_req = 1'b1; bus.alu_addr = 5'd0;
        cycle(mk("alu_r0", 3'b100, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0));
        clr_req();

        // Freeze held across UPD, ALU waiting
        bus.alu_req = 1'b1; bus.alu_addr = 5'd1;
        load(5'd4, 1'b1, 5'd12);
        cycle(mk("frz_c0", 3'b010, 2'b01, 1'b1, 5'd4, 1'b1, 1'b0));
        drop_lsu();
        wb_freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ef = mk($sformatf("frz_hold%0d", i), 3'b000, 2'b00, 1'b0, 5'd0, 1'b0, 1'b1);
            ef.chk_port = 1'b0;
            cycle(ef);
        end
        wb_freeze = 1'b0;
        cycle(mk("frz_ea", 3'b000, 2'b11, 1'b1, 5'd12, 1'b1, 1'b1));
        cycle(mk("frz_alu", 3'b100, 2'b00, 1'b1, 5'd1, 1'b0, 1'b0));
        clr_req();

        // Reset while in UPD drops the EA write
        load(5'd4, 1'b1, 5'd13);
        cycle(mk("rst_c0", 3'b010, 2'b01, 1'b1, 5'd4, 1'b0, 1'b0));
        drop_lsu();
        rst = 1'b0;
        cycle(mk("rst_in", 3'b000, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0));
        rst = 1'b1;
        cycle(mk("rst_after", 3'b000, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
